mem_bus_arbiter: RTL

Shares the single on-board SRAM between the instruction-fetch port and the data-memory port of the CPU, and steers data accesses in the peripheral window (address[31:28] ≥ 4) to the peripheral bus. Sits between the pipeline's IF/MEM stages and the external SRAM and peripheral interconnect. Sequences every SRAM access with a fixed wait count and returns results through a req/ack handshake. A peripheral access runs concurrently with an SRAM fetch.

---
 rtl/mem_bus_arbiter_if.sv | 49 ++++
 rtl/mem_bus_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the CPU IF/MEM ports, the arbiter, the SRAM and the
// peripheral interconnect. slave = arbiter view, master = CPU/memory side.
interface mem_bus_arbiter_if #(
   parameter int ADDR_W = 20
);
   // instruction-fetch port
   logic              if_req;
   logic [31:0]       if_addr;
   logic              if_ack;
   logic [31:0]       if_rdata;
   // data-memory port
   logic              mem_req;
   logic              mem_we;
   logic [3:0]        mem_be;
   logic [31:0]       mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_ack;
   logic [31:0]       mem_rdata;
   // SRAM side
   logic              ram_en;
   logic              ram_we;
   logic [3:0]        ram_be;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;
   // peripheral side
   logic              peri_en;
   logic              peri_we;
   logic [31:0]       peri_addr;
   logic [31:0]       peri_wdata;
   logic [31:0]       peri_rdata;
   logic              peri_ready;

   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
             ram_rdata, peri_rdata, peri_ready,
      output if_ack, if_rdata, mem_ack, mem_rdata,
             ram_en, ram_we, ram_be, ram_addr, ram_wdata,
             peri_en, peri_we, peri_addr, peri_wdata
   );

   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
             ram_rdata, peri_rdata, peri_ready,
      input  if_ack, if_rdata, mem_ack, mem_rdata,
             ram_en, ram_we, ram_be, ram_addr, ram_wdata,
             peri_en, peri_we, peri_addr, peri_wdata
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM between fetch and data ports (data has priority) and steers
// data accesses with addr[31:28] >= 4 to the peripheral bus. The SRAM and
// peripheral FSMs run independently, so a fetch can overlap a peripheral access.
module mem_bus_arbiter #(
   parameter int RAM_WAIT = 2,   // SRAM access length in cycles, 1..15
   parameter int ADDR_W   = 20
) (
   input logic              clk,
   input logic              rst,
   mem_bus_arbiter_if.slave bus
);
   typedef enum logic [1:0] {R_IDLE, R_BUSY, R_ACK} r_state_e;
   typedef enum logic [1:0] {P_IDLE, P_BUSY, P_ACK} p_state_e;

   r_state_e          r_state_q, r_state_d;
   p_state_e          p_state_q, p_state_d;

   // SRAM side registers
   logic [3:0]        cnt_q, cnt_d;
   logic              gnt_mem_q, gnt_mem_d;
   logic              ram_en_q, ram_en_d;
   logic              ram_we_q, ram_we_d;
   logic [3:0]        ram_be_q, ram_be_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [31:0]       ram_wdata_q, ram_wdata_d;
   logic              if_ack_q, if_ack_d;
   logic [31:0]       if_rdata_q, if_rdata_d;
   logic              sram_mem_ack_q, sram_mem_ack_d;
   logic [31:0]       sram_mem_rdata_q, sram_mem_rdata_d;

   // peripheral side registers
   logic              peri_en_q, peri_en_d;
   logic              peri_we_q, peri_we_d;
   logic [31:0]       peri_addr_q, peri_addr_d;
   logic [31:0]       peri_wdata_q, peri_wdata_d;
   logic              peri_ack_q, peri_ack_d;
   logic [31:0]       peri_mem_rdata_q, peri_mem_rdata_d;

   logic mem_is_peri, mem_sram_req, peri_grant, r_last;
   logic unused_addr_bits;

   assign mem_is_peri  = bus.mem_addr[31:28] >= 4'd4;
   // Each data request belongs to exactly one FSM; the cross-FSM guards only
   // matter if a requester breaks protocol and swaps address mid-flight.
   assign mem_sram_req = bus.mem_req && !mem_is_peri && (p_state_q == P_IDLE);
   assign peri_grant   = bus.mem_req && mem_is_peri && !bus.mem_ack &&
                         !((r_state_q != R_IDLE) && gnt_mem_q);
   assign r_last       = (cnt_q == 4'(RAM_WAIT - 1));
   assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                               bus.mem_addr[1:0]};

   // State and output registers; reset clears everything, aborting any access
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state_q        <= R_IDLE;
         p_state_q        <= P_IDLE;
         cnt_q            <= '0;
         gnt_mem_q        <= 1'b0;
         ram_en_q         <= 1'b0;
         ram_we_q         <= 1'b0;
         ram_be_q         <= '0;
         ram_addr_q       <= '0;
         ram_wdata_q      <= '0;
         if_ack_q         <= 1'b0;
         if_rdata_q       <= '0;
         sram_mem_ack_q   <= 1'b0;
         sram_mem_rdata_q <= '0;
         peri_en_q        <= 1'b0;
         peri_we_q        <= 1'b0;
         peri_addr_q      <= '0;
         peri_wdata_q     <= '0;
         peri_ack_q       <= 1'b0;
         peri_mem_rdata_q <= '0;
      end else begin
         r_state_q        <= r_state_d;
         p_state_q        <= p_state_d;
         cnt_q            <= cnt_d;
         gnt_mem_q        <= gnt_mem_d;
         ram_en_q         <= ram_en_d;
         ram_we_q         <= ram_we_d;
         ram_be_q         <= ram_be_d;
         ram_addr_q       <= ram_addr_d;
         ram_wdata_q      <= ram_wdata_d;
         if_ack_q         <= if_ack_d;
         if_rdata_q       <= if_rdata_d;
         sram_mem_ack_q   <= sram_mem_ack_d;
         sram_mem_rdata_q <= sram_mem_rdata_d;
         peri_en_q        <= peri_en_d;
         peri_we_q        <= peri_we_d;
         peri_addr_q      <= peri_addr_d;
         peri_wdata_q     <= peri_wdata_d;
         peri_ack_q       <= peri_ack_d;
         peri_mem_rdata_q <= peri_mem_rdata_d;
      end
   end

   // SRAM FSM next state: grant, hold for RAM_WAIT cycles, one ack cycle
   always_comb begin
      r_state_d = r_state_q;
      case (r_state_q)
         R_IDLE:  if (mem_sram_req || bus.if_req) r_state_d = R_BUSY;
         R_BUSY:  if (r_last) r_state_d = R_ACK;
         R_ACK:   r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   // SRAM outputs: controls latched at grant and cleared on the last busy
   // cycle, so they are only non-zero while BUSY; acks last one cycle
   always_comb begin
      cnt_d            = cnt_q;
      gnt_mem_d        = gnt_mem_q;
      ram_en_d         = ram_en_q;
      ram_we_d         = ram_we_q;
      ram_be_d         = ram_be_q;
      ram_addr_d       = ram_addr_q;
      ram_wdata_d      = ram_wdata_q;
      if_ack_d         = 1'b0;
      if_rdata_d       = '0;
      sram_mem_ack_d   = 1'b0;
      sram_mem_rdata_d = '0;
      case (r_state_q)
         R_IDLE: begin
            cnt_d = '0;
            if (mem_sram_req) begin
               gnt_mem_d   = 1'b1;
               ram_en_d    = 1'b1;
               ram_we_d    = bus.mem_we;
               ram_be_d    = bus.mem_be;
               ram_addr_d  = bus.mem_addr[ADDR_W+1:2];
               ram_wdata_d = bus.mem_wdata;
            end else if (bus.if_req) begin
               gnt_mem_d   = 1'b0;
               ram_en_d    = 1'b1;
               ram_we_d    = 1'b0;
               ram_be_d    = 4'hF;
               ram_addr_d  = bus.if_addr[ADDR_W+1:2];
               ram_wdata_d = '0;
            end
         end
         R_BUSY: begin
            if (r_last) begin
               cnt_d       = '0;
               ram_en_d    = 1'b0;
               ram_we_d    = 1'b0;
               ram_be_d    = '0;
               ram_addr_d  = '0;
               ram_wdata_d = '0;
               if (gnt_mem_q) begin
                  sram_mem_ack_d   = 1'b1;
                  sram_mem_rdata_d = bus.ram_rdata;
               end else begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = bus.ram_rdata;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: ;
      endcase
   end

   // Peripheral FSM next state: wait for peri_ready, then one ack cycle
   always_comb begin
      p_state_d = p_state_q;
      case (p_state_q)
         P_IDLE:  if (peri_grant) p_state_d = P_BUSY;
         P_BUSY:  if (bus.peri_ready) p_state_d = P_ACK;
         P_ACK:   p_state_d = P_IDLE;
         default: p_state_d = P_IDLE;
      endcase
   end

   // Peripheral outputs: top nibble rebased by -4 (mod 16) into the peri window
   always_comb begin
      peri_en_d        = peri_en_q;
      peri_we_d        = peri_we_q;
      peri_addr_d      = peri_addr_q;
      peri_wdata_d     = peri_wdata_q;
      peri_ack_d       = 1'b0;
      peri_mem_rdata_d = '0;
      case (p_state_q)
         P_IDLE: begin
            if (peri_grant) begin
               peri_en_d    = 1'b1;
               peri_we_d    = bus.mem_we;
               peri_addr_d  = {bus.mem_addr[31:28] - 4'd4, bus.mem_addr[27:0]};
               peri_wdata_d = bus.mem_wdata;
            end
         end
         P_BUSY: begin
            if (bus.peri_ready) begin
               peri_en_d        = 1'b0;
               peri_we_d        = 1'b0;
               peri_addr_d      = '0;
               peri_wdata_d     = '0;
               peri_ack_d       = 1'b1;
               peri_mem_rdata_d = bus.peri_rdata;
            end
         end
         default: ;
      endcase
   end

   assign bus.ram_en     = ram_en_q;
   assign bus.ram_we     = ram_we_q;
   assign bus.ram_be     = ram_be_q;
   assign bus.ram_addr   = ram_addr_q;
   assign bus.ram_wdata  = ram_wdata_q;
   assign bus.if_ack     = if_ack_q;
   assign bus.if_rdata   = if_rdata_q;
   assign bus.peri_en    = peri_en_q;
   assign bus.peri_we    = peri_we_q;
   assign bus.peri_addr  = peri_addr_q;
   assign bus.peri_wdata = peri_wdata_q;
   // Both sources are zero outside their own ack cycle, so OR merges cleanly
   assign bus.mem_ack    = sram_mem_ack_q | peri_ack_q;
   assign bus.mem_rdata  = sram_mem_rdata_q | peri_mem_rdata_q;
endmodule
